// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input gate: drives all four {a,b} vectors,
// samples the gate output after a settle interval, and reports a verdict.
module gate_tt_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] idx;
    logic [3:0] settle;
    logic [3:0] exp_q;
    logic       mismatch;
    logic [2:0] err_next;

    assign mismatch = (gate_out != exp_q[idx]);
    assign err_next = err_count + {2'b00, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            settle    <= '0;
            exp_q     <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q     <= expected;
                        err_count <= '0;
                        fail_mask <= '0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        settle    <= '0;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count      <= err_next;
                        fail_mask[idx] <= 1'b1;
                    end
                    // Verdict uses the count including this last sample.
                    if (idx == 2'd3) begin
                        pass  <= (err_next == 3'd0);
                        state <= DONE;
                    end else begin
                        idx    <= idx + 2'd1;
                        settle <= '0;
                        state  <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign a    = busy & idx[1];
    assign b    = busy & idx[0];

endmodule
